sc_io_hex_display: RTL

//  Downstream consumer of the single-cycle computer's memory-mapped output ports. Each port
//  out_port0/1/2 is converted to two decimal digits and driven onto a pair of seven-segment

---
 rtl/sc_io_hex_display_pkg.sv | 37 +++
 rtl/sc_io_hex_display_seg7.sv | 27 ++
 rtl/sc_io_hex_display.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/sc_io_hex_display_pkg.sv
// Shared types and constants for the output-port hex display.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package sc_io_hex_display_pkg;

  localparam int BCD_W = 12;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_D0    = 7'h40;
  localparam logic [6:0] SEG_D1    = 7'h79;
  localparam logic [6:0] SEG_D2    = 7'h24;
  localparam logic [6:0] SEG_D3    = 7'h30;
  localparam logic [6:0] SEG_D4    = 7'h19;
  localparam logic [6:0] SEG_D5    = 7'h12;
  localparam logic [6:0] SEG_D6    = 7'h02;
  localparam logic [6:0] SEG_D7    = 7'h78;
  localparam logic [6:0] SEG_D8    = 7'h00;
  localparam logic [6:0] SEG_D9    = 7'h10;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic [BCD_W-1:0] bcd_adj(
    input logic [BCD_W-1:0] b
  );
    logic [BCD_W-1:0] r;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      else                     r[4*i +: 4] = b[4*i +: 4];
    end
    return r;
  endfunction

endpackage

// File: rtl/sc_io_hex_display_seg7.sv
// BCD digit to active-low seven-segment code.
// Non-decimal digits show blank.
module sc_seg7_decoder
  import sc_io_hex_display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (digit)
      4'd0:    seg = SEG_D0;
      4'd1:    seg = SEG_D1;
      4'd2:    seg = SEG_D2;
      4'd3:    seg = SEG_D3;
      4'd4:    seg = SEG_D4;
      4'd5:    seg = SEG_D5;
      4'd6:    seg = SEG_D6;
      4'd7:    seg = SEG_D7;
      4'd8:    seg = SEG_D8;
      4'd9:    seg = SEG_D9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sc_io_hex_display.sv
// Round-robin double-dabble converter driving three
// two-digit seven-segment pairs from the CPU output ports.
module sc_io_hex_display
  import sc_io_hex_display_pkg::*;
#(
  parameter int IN_W     = 8,
  parameter bit BLANK_LZ = 1'b0
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] out_port0,
  input  logic [31:0] out_port1,
  input  logic [31:0] out_port2,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic [2:0]  ovf,
  output logic        busy,
  output logic [1:0]  conv_idx
);

  localparam logic [3:0] CNT_LAST = 4'(IN_W - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [IN_W-1:0]     bin_q, bin_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic [1:0]          idx_q, idx_d;
  logic                busy_q, busy_d;
  logic [2:0]          ovf_q, ovf_d;
  logic [6:0]          hex_q [6];
  logic [6:0]          hex_d [6];

  logic [IN_W-1:0]       port_sel;
  logic [BCD_W+IN_W-1:0] shift_w;
  logic [6:0]            seg_tens, seg_ones;
  logic [6:0]            tens_w, ones_w;
  logic                  hund_nz;
  logic                  unused_hi;

  assign unused_hi = ^{out_port0[31:IN_W],
                       out_port1[31:IN_W],
                       out_port2[31:IN_W]};

  always_comb begin
    port_sel = out_port2[IN_W-1:0];
    unique case (idx_q)
      2'd0:    port_sel = out_port0[IN_W-1:0];
      2'd1:    port_sel = out_port1[IN_W-1:0];
      default: port_sel = out_port2[IN_W-1:0];
    endcase
  end

  sc_seg7_decoder u_dec_tens (
    .digit (bcd_q[7:4]),
    .seg   (seg_tens)
  );

  sc_seg7_decoder u_dec_ones (
    .digit (bcd_q[3:0]),
    .seg   (seg_ones)
  );

  // Any hundreds digit means the pair cannot show the value.
  always_comb begin
    hund_nz = (bcd_q[11:8] != 4'd0);
    tens_w  = seg_tens;
    ones_w  = seg_ones;
    if (hund_nz) begin
      tens_w = SEG_DASH;
      ones_w = SEG_DASH;
    end else if (BLANK_LZ && bcd_q[7:4] == 4'd0) begin
      tens_w = SEG_BLANK;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    ovf_d   = ovf_q;
    hex_d   = hex_q;
    shift_w = {bcd_adj(bcd_q), bin_q} << 1;
    unique case (state_q)
      ST_LOAD: begin
        bin_d   = port_sel;
        bcd_d   = '0;
        cnt_d   = '0;
        busy_d  = 1'b1;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        {bcd_d, bin_d} = shift_w;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        hex_d[{idx_q, 1'b0}] = ones_w;
        hex_d[{idx_q, 1'b1}] = tens_w;
        ovf_d[idx_q]         = hund_nz;
        idx_d   = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        busy_d  = 1'b0;
        state_d = ST_LOAD;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      idx_q   <= 2'd0;
      busy_q  <= 1'b0;
      ovf_q   <= '0;
      for (int i = 0; i < 6; i++) hex_q[i] <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < 6; i++) hex_q[i] <= hex_d[i];
    end
  end

  assign hex0     = hex_q[0];
  assign hex1     = hex_q[1];
  assign hex2     = hex_q[2];
  assign hex3     = hex_q[3];
  assign hex4     = hex_q[4];
  assign hex5     = hex_q[5];
  assign ovf      = ovf_q;
  assign busy     = busy_q;
  assign conv_idx = idx_q;

endmodule
